// File: rtl/wb_csr_bank_if.sv
// Wishbone classic slave bundle used by wb_csr_bank.
interface wb_csr_bank_if #(
    parameter int DWIDTH = 32
);
    logic                  wbs_cyc_i;
    logic                  wbs_stb_i;
    logic                  wbs_we_i;
    logic [DWIDTH/8-1:0]   wbs_sel_i;
    logic [31:0]           wbs_adr_i;
    logic [DWIDTH-1:0]     wbs_dat_i;
    logic                  wbs_ack_o;
    logic                  wbs_err_o;
    logic [DWIDTH-1:0]     wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_err_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_err_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_csr_bank.sv
// Wishbone CSR bank: CTRL/STATUS accelerator handshake plus DEPTH-2 config registers.
// Optional macro CSR_BANK_IRQ_EN enables the IRQ_EN bit and the registered irq_o.
module wb_csr_bank #(
    parameter int                DWIDTH  = 32,
    parameter int                DEPTH   = 8,
    parameter logic [DWIDTH-1:0] CFG_RST = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    wb_csr_bank_if.slave                 wbs,
    output logic [(DEPTH-2)*DWIDTH-1:0]  cfg_o,
    output logic                         start_o,
    input  logic                         done_i,
    output logic                         busy_o,
    output logic                         irq_o
);
    localparam int SELW = DWIDTH / 8;
    localparam int OFFW = $clog2(SELW);
    localparam int IDXW = 32 - OFFW;
    localparam int AW   = $clog2(DEPTH);

    typedef enum logic {S_IDLE, S_BUSY} job_state_t;

    job_state_t                    state_q, state_d;
    logic [IDXW-1:0]               idx_p0;
    logic [AW-1:0]                 ridx_p0;
    logic                          req_p0, hit_p0, wr_p0;
    logic                          ctrl_wr_p0, stat_wr_p0;
    logic                          start_req_p0, start_acc_p0, done_hit_p0, done_clr_p0;
    logic                          busy;
    logic [DWIDTH-1:0]             rd_val_p0;
    logic [DEPTH-1:2][DWIDTH-1:0]  cfg_q;
    logic                          done_q, irq_en_q;
    logic                          ack_p1, err_p1, start_p1;
    logic [DWIDTH-1:0]             rdat_p1;
    logic                          unused_adr;

    function automatic logic [DWIDTH-1:0] merge_lanes(
        input logic [DWIDTH-1:0] old_v,
        input logic [DWIDTH-1:0] new_v,
        input logic [SELW-1:0]   sel
    );
        logic [DWIDTH-1:0] res;
        res = old_v;
        for (int b = 0; b < SELW; b++) begin
            if (sel[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    // Stage p0: decode the request presented on the bus this cycle.
    assign unused_adr   = ^wbs.wbs_adr_i[OFFW-1:0];
    assign idx_p0       = wbs.wbs_adr_i[31:OFFW];
    assign ridx_p0      = idx_p0[AW-1:0];
    assign req_p0       = wbs.wbs_cyc_i && wbs.wbs_stb_i && !ack_p1 && !err_p1;
    assign hit_p0       = req_p0 && (idx_p0 < IDXW'(DEPTH));
    assign wr_p0        = hit_p0 && wbs.wbs_we_i;
    assign ctrl_wr_p0   = wr_p0 && (ridx_p0 == '0) && wbs.wbs_sel_i[0];
    assign stat_wr_p0   = wr_p0 && (ridx_p0 == AW'(1)) && wbs.wbs_sel_i[0];
    assign start_req_p0 = ctrl_wr_p0 && wbs.wbs_dat_i[0];
    assign done_clr_p0  = stat_wr_p0 && wbs.wbs_dat_i[1];

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_req_p0) state_d = S_BUSY;
            S_BUSY:  if (done_i)       state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A START arriving with done_i while busy is dropped: the running job finishes instead.
    always_comb begin
        busy         = (state_q == S_BUSY);
        start_acc_p0 = start_req_p0 && !busy;
        done_hit_p0  = done_i && busy;
    end

    always_comb begin
        rd_val_p0 = '0;
        if (ridx_p0 == '0) begin
            rd_val_p0[1] = irq_en_q;
        end else if (ridx_p0 == AW'(1)) begin
            rd_val_p0[1] = done_q;
            rd_val_p0[0] = busy;
        end else begin
            rd_val_p0 = cfg_q[ridx_p0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 2; i < DEPTH; i++) cfg_q[i] <= CFG_RST;
        end else if (wr_p0 && (ridx_p0 >= AW'(2))) begin
            cfg_q[ridx_p0] <= merge_lanes(cfg_q[ridx_p0], wbs.wbs_dat_i, wbs.wbs_sel_i);
        end
    end

    // DONE set has priority over a simultaneous write-1-to-clear.
    always_ff @(posedge clk) begin
        if (reset)            done_q <= 1'b0;
        else if (done_hit_p0) done_q <= 1'b1;
        else if (done_clr_p0) done_q <= 1'b0;
    end

`ifdef CSR_BANK_IRQ_EN
    logic irq_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en_q <= 1'b0;
            irq_p1   <= 1'b0;
        end else begin
            if (ctrl_wr_p0) irq_en_q <= wbs.wbs_dat_i[1];
            irq_p1 <= done_q && irq_en_q;
        end
    end

    assign irq_o = irq_p1;
`else
    assign irq_en_q = 1'b0;
    assign irq_o    = 1'b0;
`endif

    // Stage p1: registered bus response and start pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_p1   <= 1'b0;
            err_p1   <= 1'b0;
            start_p1 <= 1'b0;
            rdat_p1  <= '0;
        end else begin
            ack_p1   <= hit_p0;
            err_p1   <= req_p0 && !hit_p0;
            start_p1 <= start_acc_p0;
            if (req_p0 && !hit_p0)            rdat_p1 <= '0;
            else if (hit_p0 && !wbs.wbs_we_i) rdat_p1 <= rd_val_p0;
        end
    end

    assign wbs.wbs_ack_o = ack_p1;
    assign wbs.wbs_err_o = err_p1;
    assign wbs.wbs_dat_o = rdat_p1;
    assign start_o       = start_p1;
    assign busy_o        = busy;
    assign cfg_o         = cfg_q;
endmodule

// File: tb/tb_wb_csr_bank.sv
// Self-checking bench for wb_csr_bank: directed scenarios then random traffic against a register-level model.
module tb_wb_csr_bank;
    localparam int          DWIDTH  = 32;
    localparam int          DEPTH   = 8;
    localparam logic [31:0] CFG_RST = 32'h0;
`ifdef CSR_BANK_IRQ_EN
    localparam bit IRQ_FEAT = 1'b1;
`else
    localparam bit IRQ_FEAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic done_i;
    logic start_o, busy_o, irq_o;
    logic [(DEPTH-2)*DWIDTH-1:0] cfg_o;

    wb_csr_bank_if #(.DWIDTH(DWIDTH)) bus ();

    wb_csr_bank #(.DWIDTH(DWIDTH), .DEPTH(DEPTH), .CFG_RST(CFG_RST)) dut (
        .clk(clk), .reset(reset), .wbs(bus), .cfg_o(cfg_o),
        .start_o(start_o), .done_i(done_i), .busy_o(busy_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: what software would see in each register.
    logic [31:0] m_cfg [2:DEPTH-1];
    bit          m_busy, m_done, m_irq_en, m_irq, m_ack, m_err, m_start;
    logic [31:0] m_dat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        logic [31:0] m;
        m = 32'h0;
        if (sel[0]) m = m | 32'h0000_00FF;
        if (sel[1]) m = m | 32'h0000_FF00;
        if (sel[2]) m = m | 32'h00FF_0000;
        if (sel[3]) m = m | 32'hFF00_0000;
        return m;
    endfunction

    function automatic logic [31:0] ref_read(input int unsigned idx);
        if (idx == 0) return {30'h0, m_irq_en, 1'b0};
        if (idx == 1) return {30'h0, m_done, m_busy};
        return m_cfg[idx];
    endfunction

    task automatic model_edge(input bit req, input bit we, input logic [31:0] adr,
                              input logic [31:0] wd, input logic [3:0] sel,
                              input bit dn, input bit rst);
        bit irq_nx, start, clr;
        int unsigned idx;
        if (rst) begin
            for (int i = 2; i < DEPTH; i++) m_cfg[i] = CFG_RST;
            {m_busy, m_done, m_irq_en, m_irq, m_ack, m_err, m_start} = '0;
            m_dat = 32'h0;
            return;
        end
        irq_nx = IRQ_FEAT && m_done && m_irq_en;
        start  = 1'b0;
        clr    = 1'b0;
        idx    = adr / 4;
        m_ack  = 1'b0;
        m_err  = 1'b0;
        if (req) begin
            if (idx >= DEPTH) begin
                m_err = 1'b1;
                m_dat = 32'h0;
            end else begin
                m_ack = 1'b1;
                if (!we) m_dat = ref_read(idx);
                else if (idx == 0) begin
                    if (sel[0]) begin
                        if (IRQ_FEAT) m_irq_en = wd[1];
                        start = wd[0] && !m_busy;
                    end
                end else if (idx == 1) clr = sel[0] && wd[1];
                else m_cfg[idx] = (m_cfg[idx] & ~lane_mask(sel)) | (wd & lane_mask(sel));
            end
        end
        if (dn && m_busy) begin
            m_busy = 1'b0;
            m_done = 1'b1;
        end else begin
            if (clr)   m_done = 1'b0;
            if (start) m_busy = 1'b1;
        end
        m_start = start;
        m_irq   = irq_nx;
    endtask

    task automatic compare_all();
        chk("ack",   {31'h0, bus.wbs_ack_o}, {31'h0, m_ack});
        chk("err",   {31'h0, bus.wbs_err_o}, {31'h0, m_err});
        chk("dat",   bus.wbs_dat_o, m_dat);
        chk("start", {31'h0, start_o}, {31'h0, m_start});
        chk("busy",  {31'h0, busy_o},  {31'h0, m_busy});
        chk("irq",   {31'h0, irq_o},   {31'h0, m_irq});
        for (int i = 2; i < DEPTH; i++)
            chk($sformatf("cfg%0d", i), cfg_o[(i-2)*32 +: 32], m_cfg[i]);
    endtask

    task automatic idle(input bit dn, input bit rst);
        done_i = dn;
        reset  = rst;
        @(posedge clk);
        model_edge(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, dn, rst);
        #1;
        compare_all();
        done_i = 1'b0;
        reset  = 1'b0;
    endtask

    task automatic xfer(input bit we, input logic [31:0] adr, input logic [31:0] wd,
                        input logic [3:0] sel, input bit dn, input bit rst,
                        output logic [31:0] rdat, output logic st, output logic er);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = wd;
        bus.wbs_sel_i = sel;
        done_i        = dn;
        reset         = rst;
        @(posedge clk);
        model_edge(1'b1, we, adr, wd, sel, dn, rst);
        #1;
        compare_all();
        rdat = bus.wbs_dat_o;
        st   = start_o;
        er   = bus.wbs_err_o;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        done_i        = 1'b0;
        reset         = 1'b0;
        idle(1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        st, er;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = 32'h0;
        bus.wbs_dat_i = 32'h0;
        done_i = 1'b0;
        reset  = 1'b1;
        @(posedge clk);
        #1;
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b0);

        // Partial-lane write then readback.
        xfer(1'b1, 32'h08, 32'hDEAD_BEEF, 4'b0101, 1'b0, 1'b0, rd, st, er);
        xfer(1'b0, 32'h08, 32'h0, 4'hF, 1'b0, 1'b0, rd, st, er);
        chk("s031_rd", rd, 32'h00AD_00EF);
        chk("s031_cfg", cfg_o[31:0], 32'h00AD_00EF);

        // Out-of-range read.
        xfer(1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 1'b0, rd, st, er);
        chk("s032_err", {31'h0, er}, 32'h1);
        chk("s032_dat", rd, 32'h0);

        // START, ignored second START, done.
        xfer(1'b1, 32'h00, 32'h1, 4'h1, 1'b0, 1'b0, rd, st, er);
        chk("s033_start1", {31'h0, st}, 32'h1);
        xfer(1'b0, 32'h04, 32'h0, 4'hF, 1'b0, 1'b0, rd, st, er);
        chk("s033_stat1", rd, 32'h1);
        xfer(1'b1, 32'h00, 32'h1, 4'h1, 1'b0, 1'b0, rd, st, er);
        chk("s033_start2", {31'h0, st}, 32'h0);
        idle(1'b1, 1'b0);
        xfer(1'b0, 32'h04, 32'h0, 4'hF, 1'b0, 1'b0, rd, st, er);
        chk("s033_stat2", rd, 32'h2);

        // W1C of DONE racing a done_i while busy: set wins.
        xfer(1'b1, 32'h00, 32'h1, 4'h1, 1'b0, 1'b0, rd, st, er);
        xfer(1'b1, 32'h04, 32'h2, 4'h1, 1'b1, 1'b0, rd, st, er);
        xfer(1'b0, 32'h04, 32'h0, 4'hF, 1'b0, 1'b0, rd, st, er);
        chk("s034_stat", rd, 32'h2);

        // IRQ path: enable, clear DONE, run a job, then clear again.
        xfer(1'b1, 32'h00, 32'h2, 4'h1, 1'b0, 1'b0, rd, st, er);
        xfer(1'b1, 32'h04, 32'h2, 4'h1, 1'b0, 1'b0, rd, st, er);
        chk("s035_irq_lo", {31'h0, irq_o}, 32'h0);
        xfer(1'b1, 32'h00, 32'h3, 4'h1, 1'b0, 1'b0, rd, st, er);
        idle(1'b1, 1'b0);
        chk("s035_irq_lag", {31'h0, irq_o}, 32'h0);
        idle(1'b0, 1'b0);
        chk("s035_irq_hi", {31'h0, irq_o}, {31'h0, IRQ_FEAT});
        xfer(1'b1, 32'h04, 32'h2, 4'h1, 1'b0, 1'b0, rd, st, er);
        chk("s035_irq_off", {31'h0, irq_o}, 32'h0);

        // START together with done_i while busy completes the job only.
        xfer(1'b1, 32'h00, 32'h1, 4'h1, 1'b0, 1'b0, rd, st, er);
        xfer(1'b1, 32'h00, 32'h1, 4'h1, 1'b1, 1'b0, rd, st, er);
        chk("s025_start", {31'h0, st}, 32'h0);
        chk("s025_busy", {31'h0, busy_o}, 32'h0);

        // Randomised traffic including out-of-range, partial lanes and done pulses.
        for (int n = 0; n < 250; n++) begin
            logic [31:0] adr;
            adr = $urandom_range(0, DEPTH + 1) * 4 + $urandom_range(0, 3);
            xfer(1'($urandom_range(0, 1)), adr, $urandom, 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0), 1'b0, rd, st, er);
            if ($urandom_range(0, 4) == 0) idle(($urandom_range(0, 1) == 1), 1'b0);
        end

        // Reset arriving with a write: no ack, everything back to reset values.
        xfer(1'b1, 32'h00, 32'h1, 4'h1, 1'b0, 1'b0, rd, st, er);
        xfer(1'b1, 32'h0C, 32'h1234_5678, 4'hF, 1'b0, 1'b1, rd, st, er);
        chk("s036_cfg3", cfg_o[63:32], CFG_RST);
        chk("s036_busy", {31'h0, busy_o}, 32'h0);
        xfer(1'b0, 32'h04, 32'h0, 4'hF, 1'b0, 1'b0, rd, st, er);
        chk("s036_stat", rd, 32'h0);

        // A busy job is forgotten across reset.
        xfer(1'b1, 32'h00, 32'h1, 4'h1, 1'b0, 1'b0, rd, st, er);
        idle(1'b0, 1'b1);
        chk("s028_busy", {31'h0, busy_o}, 32'h0);
        idle(1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/wb_csr_bank.md
WB_CSR_BANK -- requirements
Module: wb_csr_bank

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, Wishbone data width in bits; legal values are 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 8, total register count; legal range is 3..64.
REQ-003 SHALL have parameter CFG_RST, default 0, reset value of every general config register.
REQ-004 SHALL have port clk, input, 1 bit, clock; reset is synchronous, active-high; clock is clk.
REQ-005 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have ports wbs_cyc_i / wbs_stb_i / wbs_we_i, input, 1 bit each: Wishbone classic cycle, strobe and write enable.
REQ-007 SHALL have port wbs_sel_i, input, DWIDTH/8 bits, byte lane select.
REQ-008 SHALL have ports wbs_adr_i, input, 32 bits (byte address), and wbs_dat_i, input, DWIDTH bits (write data).
REQ-009 SHALL have ports wbs_ack_o and wbs_err_o, output, 1 bit each, and wbs_dat_o, output, DWIDTH bits (read data).
REQ-010 SHALL have port cfg_o, output, (DEPTH-2)*DWIDTH bits: registers 2..DEPTH-1 flattened, register 2 in the LSBs.
REQ-011 SHALL have port start_o, output, 1 bit, one-cycle accelerator start pulse.
REQ-012 SHALL have port done_i, input, 1 bit, accelerator completion pulse.
REQ-013 SHALL have ports busy_o and irq_o, output, 1 bit each.

Function
REQ-014 Register index SHALL be wbs_adr_i >> log2(DWIDTH/8); low byte-offset bits are ignored.
REQ-015 A request SHALL be sampled when cyc && stb && !ack && !err; wbs_ack_o or wbs_err_o SHALL assert on the next cycle for exactly one cycle.
REQ-016 A request with index >= DEPTH SHALL assert wbs_err_o instead of ack, change no state, and return read data 0.
REQ-017 A read SHALL register the addressed value into wbs_dat_o together with ack; wbs_dat_o SHALL hold its value otherwise.
REQ-018 Writes SHALL update only the byte lanes selected in wbs_sel_i.
REQ-019 Register 0 (CTRL) SHALL map: bit0 START, write-1 and read-as-0; bit1 IRQ_EN, read/write; all other bits read 0.
REQ-020 Register 1 (STATUS) SHALL map: bit0 BUSY, read-only; bit1 DONE, sticky and write-1-to-clear; all other bits read 0.
REQ-021 Writing START=1 while not busy SHALL pulse start_o on the cycle ack asserts and set BUSY on that same cycle.
REQ-022 Writing START=1 while BUSY SHALL be ignored: no start_o pulse, ack returned normally.
REQ-023 done_i while BUSY SHALL clear BUSY and set DONE on the next cycle; done_i while idle SHALL be ignored.
REQ-024 done_i and a W1C of DONE in the same cycle SHALL leave DONE set, because set wins.
REQ-025 A START write and done_i in the same cycle SHALL complete the current job only; START is not accepted.
REQ-026 busy_o SHALL equal BUSY, and cfg_o SHALL reflect register contents continuously.

Reset
REQ-027 On reset, wbs_ack_o, wbs_err_o, wbs_dat_o, start_o, BUSY, DONE, IRQ_EN and irq_o SHALL be 0, and every config register SHALL be CFG_RST.
REQ-028 Reset asserted mid-transaction SHALL abort it with no ack; a pending busy job SHALL be forgotten.

Configuration
REQ-029 With macro CSR_BANK_IRQ_EN defined, irq_o SHALL be registered as DONE && IRQ_EN, one cycle after either changes.
REQ-030 Without CSR_BANK_IRQ_EN, irq_o SHALL be constant 0, IRQ_EN SHALL read 0 and ignore writes, and all other behaviour is unchanged.

Verification
REQ-031 Scenario: write 0xDEADBEEF to address 0x08 with sel=4'b0101 after reset -> one-cycle ack, then read of 0x08 returns 0x00AD00EF and cfg_o[31:0]=0x00AD00EF.
REQ-032 Scenario: read from address 0x20 with DEPTH=8 -> wbs_err_o for one cycle, no ack, dat_o=0, no register changed.
REQ-033 Scenario: write 0x1 to address 0x00 -> start_o pulses once and STATUS reads 0x1; a second START write gives no pulse; done_i pulse then makes STATUS read 0x2.
REQ-034 Scenario: DONE=1, then W1C 0x2 to address 0x04 in the same cycle as a done_i pulse while busy -> STATUS reads 0x2.
REQ-035 Scenario (CSR_BANK_IRQ_EN): write 0x2 to CTRL, run START/done_i -> irq_o rises one cycle after DONE; W1C of DONE drops irq_o one cycle later; without the macro irq_o stays 0.
REQ-036 Scenario: reset asserted one cycle after a sampled write -> no ack, all state at reset values, cfg_o equals CFG_RST replicated.
